// File: rtl/mul_result_queue.sv
// mul_result_queue
// ----------------
// Result buffer behind the sequential multiplier. Each completed 66-bit
// product is reduced to its RV32M result word (chosen by funct3). The word is
// stored with its destination tags in a small circular FIFO. The FIFO drains
// onto the common data bus under a valid/ready handshake.
//
// Optional feature macro: MUL_RESULT_BYPASS_EN
//   When defined, a result that arrives while the queue is empty is presented
//   on the CDB in the same cycle. If the CDB also grants, the result is
//   consumed without being written to storage.
//
// Parameters:
//   DEPTH    FIFO entries (power of two, >= 2)
//   P_WIDTH  physical register address width
//   ROB_W    ROB index width
//
// Ports:
//   i_clk            clock, all state updates on posedge
//   i_rst            synchronous active-high reset
//   i_flush          mispredict flush: empties queue, drops same-cycle result
//   i_in_valid       one-cycle pulse, multiplier result valid
//   i_in_product     66-bit two's-complement product
//   i_in_funct3      000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
//   i_in_rd_paddr    destination physical register
//   i_in_rob_idx     ROB entry
//   o_mul_hold       freezes the multiplier when the queue is nearly full
//   o_cdb_valid      head entry valid
//   i_cdb_ready      CDB grant; pop on o_cdb_valid && i_cdb_ready
//   o_cdb_data       selected result word of the head entry
//   o_cdb_rd_paddr   head destination register
//   o_cdb_rob_idx    head ROB index
//   o_overflow_err   sticky: a result arrived while full with no pop
module mul_result_queue #(
  parameter int DEPTH   = 4,
  parameter int P_WIDTH = 6,
  parameter int ROB_W   = 5
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_flush,
  input  logic               i_in_valid,
  input  logic [65:0]        i_in_product,
  input  logic [2:0]         i_in_funct3,
  input  logic [P_WIDTH-1:0] i_in_rd_paddr,
  input  logic [ROB_W-1:0]   i_in_rob_idx,
  output logic               o_mul_hold,
  output logic               o_cdb_valid,
  input  logic               i_cdb_ready,
  output logic [31:0]        o_cdb_data,
  output logic [P_WIDTH-1:0] o_cdb_rd_paddr,
  output logic [ROB_W-1:0]   o_cdb_rob_idx,
  output logic               o_overflow_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 32 + P_WIDTH + ROB_W;

  localparam logic [CNT_W-1:0] C_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] C_HOLD = CNT_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] C_PTR_ONE = PTR_W'(1);
  localparam logic [ENT_W-1:0] C_ENT_ZERO = {ENT_W{1'b0}};

  // RV32M result word. Operands arrive sign/zero-extended to 33 bits, so the
  // high word of the 66-bit product is exact for all three high variants.
  // The 1xx codes are never issued here and fall back to the low word.
  function automatic logic [31:0] f_select_result(input logic [63:0] product,
                                                  input logic [2:0]  funct3);
    logic [31:0] result;
    case (funct3)
      3'b000:                 result = product[31:0];
      3'b001, 3'b010, 3'b011: result = product[63:32];
      default:                result = product[31:0];
    endcase
    return result;
  endfunction

  logic [ENT_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic [ENT_W-1:0] r_head;
  logic             r_cdb_valid;
  logic             r_mul_hold;
  logic             r_overflow_err;

  logic [ENT_W-1:0] w_in_entry;
  logic [ENT_W-1:0] w_out_entry;
  logic [ENT_W-1:0] w_head_nxt;
  logic [PTR_W-1:0] w_rd_ptr_nxt;
  logic [PTR_W-1:0] w_wr_ptr_nxt;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_push;
  logic             w_pop;
  logic             w_ovf;
  logic             w_unused;

  // Bits [65:64] of the product carry no information for a 32-bit result.
  assign w_unused = &{1'b0, i_in_product[65:64]};

  assign w_in_entry = {f_select_result(i_in_product[63:0], i_in_funct3),
                       i_in_rd_paddr, i_in_rob_idx};

  // A pop under flush is treated as not having happened.
  assign w_pop = (r_count != C_ZERO) && i_cdb_ready && !i_flush;

`ifdef MUL_RESULT_BYPASS_EN
  logic w_byp;

  // Empty queue: the arriving result is shown directly on the CDB.
  assign w_byp       = (r_count == C_ZERO) && i_in_valid && !i_flush;
  assign w_push      = i_in_valid && !i_flush && ((r_count < C_FULL) || w_pop)
                       && !(w_byp && i_cdb_ready);
  assign w_out_entry = w_byp ? w_in_entry : r_head;
  assign o_cdb_valid = r_cdb_valid | w_byp;
`else
  assign w_push      = i_in_valid && !i_flush && ((r_count < C_FULL) || w_pop);
  assign w_out_entry = r_head;
  assign o_cdb_valid = r_cdb_valid;
`endif

  // A full queue with no pop has to drop the result.
  assign w_ovf = i_in_valid && !i_flush && (r_count == C_FULL) && !w_pop;

  assign o_cdb_data     = w_out_entry[ENT_W-1 -: 32];
  assign o_cdb_rd_paddr = w_out_entry[ROB_W +: P_WIDTH];
  assign o_cdb_rob_idx  = w_out_entry[ROB_W-1:0];
  assign o_mul_hold     = r_mul_hold;
  assign o_overflow_err = r_overflow_err;

  // Next pointer and occupancy values; flush overrides push and pop.
  always_comb begin
    w_rd_ptr_nxt = r_rd_ptr;
    w_wr_ptr_nxt = r_wr_ptr;
    w_count_nxt  = r_count;
    if (i_flush) begin
      w_rd_ptr_nxt = {PTR_W{1'b0}};
      w_wr_ptr_nxt = {PTR_W{1'b0}};
      w_count_nxt  = C_ZERO;
    end else begin
      if (w_push) begin
        w_wr_ptr_nxt = r_wr_ptr + C_PTR_ONE;
      end else begin
        w_wr_ptr_nxt = r_wr_ptr;
      end
      if (w_pop) begin
        w_rd_ptr_nxt = r_rd_ptr + C_PTR_ONE;
      end else begin
        w_rd_ptr_nxt = r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   w_count_nxt = r_count + C_ONE;
        2'b01:   w_count_nxt = r_count - C_ONE;
        default: w_count_nxt = r_count;
      endcase
    end
  end

  // Head entry for the next cycle. When the new head slot is the one being
  // written this cycle, take the incoming entry instead of stale storage.
  always_comb begin
    w_head_nxt = C_ENT_ZERO;
    if (w_count_nxt == C_ZERO) begin
      w_head_nxt = C_ENT_ZERO;
    end else if (w_push && (w_rd_ptr_nxt == r_wr_ptr)) begin
      w_head_nxt = w_in_entry;
    end else begin
      w_head_nxt = r_mem[w_rd_ptr_nxt];
    end
  end

  // Storage array write.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= C_ENT_ZERO;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= w_in_entry;
    end
  end

  // Pointers, occupancy, registered head/status outputs and the sticky error.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_ptr       <= {PTR_W{1'b0}};
      r_wr_ptr       <= {PTR_W{1'b0}};
      r_count        <= C_ZERO;
      r_head         <= C_ENT_ZERO;
      r_cdb_valid    <= 1'b0;
      r_mul_hold     <= 1'b0;
      r_overflow_err <= 1'b0;
    end else begin
      r_rd_ptr       <= w_rd_ptr_nxt;
      r_wr_ptr       <= w_wr_ptr_nxt;
      r_count        <= w_count_nxt;
      r_head         <= w_head_nxt;
      r_cdb_valid    <= (w_count_nxt != C_ZERO);
      // One slot of margin: a product finishing this cycle cannot be held.
      r_mul_hold     <= (w_count_nxt >= C_HOLD);
      r_overflow_err <= r_overflow_err | w_ovf;
    end
  end

endmodule

// File: tb/tb_mul_result_queue.sv
module tb_mul_result_queue;

  localparam int DEPTH = 4;
  localparam int P_W   = 6;
  localparam int ROB_W = 5;

`ifdef MUL_RESULT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic [65:0]      in_product;
  logic [2:0]       in_funct3;
  logic [P_W-1:0]   in_rd;
  logic [ROB_W-1:0] in_rob;
  logic             cdb_ready;
  logic             mul_hold;
  logic             cdb_valid;
  logic [31:0]      cdb_data;
  logic [P_W-1:0]   cdb_rd;
  logic [ROB_W-1:0] cdb_rob;
  logic             overflow_err;

  mul_result_queue #(.DEPTH(DEPTH), .P_WIDTH(P_W), .ROB_W(ROB_W)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_flush        (flush),
    .i_in_valid     (in_valid),
    .i_in_product   (in_product),
    .i_in_funct3    (in_funct3),
    .i_in_rd_paddr  (in_rd),
    .i_in_rob_idx   (in_rob),
    .o_mul_hold     (mul_hold),
    .o_cdb_valid    (cdb_valid),
    .i_cdb_ready    (cdb_ready),
    .o_cdb_data     (cdb_data),
    .o_cdb_rd_paddr (cdb_rd),
    .o_cdb_rob_idx  (cdb_rob),
    .o_overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Scoreboard of expected {data, rd, rob} in CDB order.
  logic [42:0] sb[$];
  logic [42:0] head_e;
  int          m_count = 0;
  bit          m_ovf   = 1'b0;
  bit          mon_en  = 1'b0;

  logic m_pop, m_byp, m_take, m_push, m_ovf_ev;
  assign m_pop    = (m_count != 0) && cdb_ready && !flush;
  assign m_byp    = BYP && (m_count == 0) && in_valid && !flush;
  assign m_take   = m_byp && cdb_ready;
  assign m_push   = in_valid && !flush && ((m_count < DEPTH) || m_pop) && !m_take;
  assign m_ovf_ev = in_valid && !flush && (m_count == DEPTH) && !m_pop;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sel(input logic [65:0] p, input logic [2:0] f3);
    if (f3 == 3'b001 || f3 == 3'b010 || f3 == 3'b011) return p[63:32];
    return p[31:0];
  endfunction

  // Reference occupancy / sticky error.
  always @(posedge clk) begin
    if (rst) begin
      m_count <= 0;
      m_ovf   <= 1'b0;
      mon_en  <= 1'b1;
      sb.delete();
    end else if (flush) begin
      m_count <= 0;
      sb.delete();
    end else begin
      m_count <= m_count + (m_push ? 1 : 0) - (m_pop ? 1 : 0);
      if (m_ovf_ev) m_ovf <= 1'b1;
    end
  end

  // Output monitor, away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      check("valid", {63'd0, cdb_valid}, {63'd0, (m_count != 0) || m_byp});
      check("hold", {63'd0, mul_hold}, {63'd0, m_count >= DEPTH - 1});
      check("ovf", {63'd0, overflow_err}, {63'd0, m_ovf});
      if (!cdb_valid) begin
        check("idle_payload", {21'd0, cdb_data, cdb_rd, cdb_rob}, 64'd0);
      end else if (sb.size() == 0) begin
        check("sb_empty", 64'(sb.size()), 64'd1);
      end else begin
        head_e = sb[0];
        check("data", {32'd0, cdb_data}, {32'd0, head_e[42:11]});
        check("rd", {58'd0, cdb_rd}, {58'd0, head_e[10:5]});
        check("rob", {59'd0, cdb_rob}, {59'd0, head_e[4:0]});
        if (cdb_ready) void'(sb.pop_front());
      end
    end
  end

  // One clock of stimulus starting just after a posedge.
  task automatic cyc(input logic v, input logic [2:0] f3, input logic [65:0] p,
                     input logic [P_W-1:0] r, input logic [ROB_W-1:0] rb,
                     input logic rdy, input logic fl);
    in_valid = v; in_funct3 = f3; in_product = p; in_rd = r; in_rob = rb;
    cdb_ready = rdy; flush = fl;
    #1;
    if (m_push || m_take) sb.push_back({sel(p, f3), r, rb});
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int k = 0; k < n; k++) cyc(1'b0, 3'b000, 66'd0, 6'd0, 5'd0, rdy, 1'b0);
  endtask

  task automatic push_n(input int n, input int base, input logic rdy);
    for (int k = 0; k < n; k++)
      cyc(1'b1, 3'(base + k), {2'b01, 32'hA000_0000 + 32'(base + k), 32'h0000_1000 + 32'(base + k)},
          6'(base + k), 5'(base + k), rdy, 1'b0);
  endtask

  task automatic drain(input int limit);
    for (int k = 0; k < limit && sb.size() != 0; k++) idle(1, 1'b1);
    check("drain_done", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_product = 66'd0;
    in_funct3 = 3'b000; in_rd = 6'd0; in_rob = 5'd0; cdb_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    check("rst_valid", {63'd0, cdb_valid}, 64'd0);
    check("rst_hold", {63'd0, mul_hold}, 64'd0);
    check("rst_ovf", {63'd0, overflow_err}, 64'd0);
    check("rst_payload", {21'd0, cdb_data, cdb_rd, cdb_rob}, 64'd0);

    // MULHU latency and one-cycle valid
    cyc(1'b1, 3'b011, 66'h0_FFFF_FFFE_0000_0001, 6'd7, 5'd3, 1'b1, 1'b0);
    check("lat_valid", {63'd0, cdb_valid}, BYP ? 64'd0 : 64'd1);
    check("lat_data", {32'd0, cdb_data}, BYP ? 64'd0 : 64'hFFFF_FFFE);
    idle(1, 1'b1);
    check("lat_one_cycle", {63'd0, cdb_valid}, 64'd0);

    // funct3 select
    cyc(1'b1, 3'b000, {2'b00, 32'h8000_0000, 32'h1234_5678}, 6'd1, 5'd1, 1'b1, 1'b0);
    cyc(1'b1, 3'b001, {2'b00, 32'h8000_0000, 32'h1234_5678}, 6'd2, 5'd2, 1'b1, 1'b0);
    cyc(1'b1, 3'b010, {2'b11, 32'h8000_0000, 32'h1234_5678}, 6'd3, 5'd3, 1'b1, 1'b0);
    drain(8);

    // backpressure
    push_n(2, 10, 1'b0);
    check("bp_hold2", {63'd0, mul_hold}, 64'd0);
    push_n(1, 12, 1'b0);
    check("bp_hold3", {63'd0, mul_hold}, 64'd1);
    push_n(1, 13, 1'b0);
    check("bp_full_ovf", {63'd0, overflow_err}, 64'd0);
    check("bp_full_valid", {63'd0, cdb_valid}, 64'd1);
    idle(1, 1'b1);
    check("bp_hold_cnt3", {63'd0, mul_hold}, 64'd1);
    idle(1, 1'b1);
    check("bp_hold_cnt2", {63'd0, mul_hold}, 64'd0);
    drain(8);

    // full queue, simultaneous push and pop across wrap
    push_n(4, 20, 1'b0);
    push_n(6, 24, 1'b1);
    check("pp_hold", {63'd0, mul_hold}, 64'd1);
    check("pp_ovf", {63'd0, overflow_err}, 64'd0);

    // overflow
    idle(1, 1'b0);
    cyc(1'b1, 3'b000, 66'h3_DEAD_BEEF_0BAD_F00D, 6'd63, 5'd31, 1'b0, 1'b0);
    check("ovf_set", {63'd0, overflow_err}, 64'd1);
    idle(10, 1'b0);
    check("ovf_sticky", {63'd0, overflow_err}, 64'd1);
    drain(10);

    // flush with a same-cycle result
    push_n(3, 40, 1'b0);
    cyc(1'b1, 3'b001, 66'h0_5555_AAAA_1111_2222, 6'd50, 5'd9, 1'b0, 1'b1);
    check("flush_valid", {63'd0, cdb_valid}, 64'd0);
    check("flush_hold", {63'd0, mul_hold}, 64'd0);
    check("flush_ovf", {63'd0, overflow_err}, 64'd1);
    cyc(1'b1, 3'b011, 66'h0_0BAD_CAFE_0000_0000, 6'd51, 5'd10, 1'b1, 1'b0);
    drain(6);

    // empty queue with grant: same-cycle bypass when enabled
    in_valid = 1'b1; in_funct3 = 3'b000; in_product = 66'h0_0000_0001_CAFE_F00D;
    in_rd = 6'd22; in_rob = 5'd17; cdb_ready = 1'b1; flush = 1'b0;
    #1;
    check("byp_valid", {63'd0, cdb_valid}, BYP ? 64'd1 : 64'd0);
    check("byp_data", {32'd0, cdb_data}, BYP ? 64'hCAFE_F00D : 64'd0);
    if (m_push || m_take) sb.push_back({32'hCAFE_F00D, 6'd22, 5'd17});
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("byp_after", {63'd0, cdb_valid}, BYP ? 64'd0 : 64'd1);
    drain(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
